sr_cmd_gen: RTL and testbench

Command sequencer that sits directly upstream of the team's SR flip-flop with preset/clear and drives its S, R, preset and clr inputs. It turns asynchronous-style level requests into clean, width-controlled, mutually exclusive pulses. It guarantees the flip-flop never receives S=R=1. After reset it also issues a power-on clear.

---
 rtl/sr_cmd_gen.sv | 175 +++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns level requests (set/rst/pre/clr) into clean, mutually
// exclusive, width-controlled pulses for an SR flip-flop with preset/clear,
// and issues a power-on clear after reset.
// Ports: clk, rst_n (sync, active-low); set_req/rst_req/pre_req/clr_req level
// requests (rising edge = event); S/R/preset/clr registered commands, at most
// one high; busy = FSM not IDLE; conflict = one-cycle pulse when set and rst
// collide and both are dropped.
// Optional: define SR_CMD_GEN_SYNC_EN to add a 2-flop synchronizer per request
// (request-to-output latency 3 cycles instead of 1).
module sr_cmd_gen #(
  parameter int INIT_CYCLES = 4,
  parameter int PULSE_W     = 2,
  parameter int GUARD_W     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  input  logic pre_req,
  input  logic clr_req,
  output logic S,
  output logic R,
  output logic preset,
  output logic clr,
  output logic busy,
  output logic conflict
);

  localparam int MAX_W = (INIT_CYCLES > PULSE_W)
                         ? ((INIT_CYCLES > GUARD_W) ? INIT_CYCLES : GUARD_W)
                         : ((PULSE_W > GUARD_W) ? PULSE_W : GUARD_W);
  localparam int CW = $clog2(MAX_W) + 1;

  // INIT counts down from INIT_CYCLES so clr stays up for INIT_CYCLES cycles
  // after the first edge that samples rst_n high.
  localparam logic [CW-1:0] INIT_LD  = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_W - 1);

  // Bit positions in the request / pending vectors.
  localparam int K_RST = 0;
  localparam int K_SET = 1;
  localparam int K_PRE = 2;
  localparam int K_CLR = 3;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PULSE, ST_GUARD} state_t;
  typedef enum logic [1:0] {CMD_RST, CMD_SET, CMD_PRE, CMD_CLR} cmd_t;

  state_t        state, state_nx;
  cmd_t          cmd, cmd_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    req_raw, req, req_q;
  logic [3:0]    pend, pend_nx;
  logic [3:0]    ev, eff;
  logic          decide;
  logic          conflict_nx;

  assign req_raw = {clr_req, pre_req, set_req, rst_req};

`ifdef SR_CMD_GEN_SYNC_EN
  logic [3:0] sync1, sync2;

  // Synchronizer resets to 1 so a request held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= req_raw;
      sync2 <= sync1;
    end
  end

  assign req = sync2;
`else
  assign req = req_raw;
`endif

  always_comb begin
    ev  = req & ~req_q;
    // A clr event wipes every other pending command, including same-cycle ones.
    eff = ev[K_CLR] ? 4'b1000 : (pend | ev);

    state_nx    = state;
    cmd_nx      = cmd;
    cnt_nx      = cnt;
    pend_nx     = eff;
    conflict_nx = 1'b0;
    decide      = 1'b0;

    case (state)
      ST_INIT: begin
        pend_nx = '0;
        if (cnt == '0) state_nx = ST_IDLE;
        else           cnt_nx   = cnt - CW'(1);
      end
      ST_IDLE: decide = 1'b1;
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nx = ST_GUARD;
          cnt_nx   = GUARD_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_GUARD: begin
        // The IDLE service decision is taken on the last guard cycle, so
        // back-to-back pulses are separated by exactly GUARD_W low cycles.
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          decide   = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = ST_INIT;
    endcase

    if (decide) begin
      if (eff[K_CLR]) begin
        state_nx = ST_PULSE;
        cmd_nx   = CMD_CLR;
      end else if (eff[K_PRE]) begin
        state_nx = ST_PULSE;
        cmd_nx   = CMD_PRE;
      end else if (eff[K_SET] && eff[K_RST]) begin
        // Ambiguous set+rst: drop both, flag it, no pulse.
        pend_nx[K_SET] = 1'b0;
        pend_nx[K_RST] = 1'b0;
        conflict_nx    = 1'b1;
      end else if (eff[K_SET]) begin
        state_nx = ST_PULSE;
        cmd_nx   = CMD_SET;
      end else if (eff[K_RST]) begin
        state_nx = ST_PULSE;
        cmd_nx   = CMD_RST;
      end
      if (state_nx == ST_PULSE) begin
        cnt_nx          = PULSE_LD;
        pend_nx[cmd_nx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cmd      <= CMD_CLR;
      cnt      <= INIT_LD;
      pend     <= '0;
      req_q    <= '1;
      S        <= 1'b0;
      R        <= 1'b0;
      preset   <= 1'b0;
      clr      <= 1'b1;
      conflict <= 1'b0;
    end else begin
      state    <= state_nx;
      cmd      <= cmd_nx;
      cnt      <= cnt_nx;
      pend     <= pend_nx;
      req_q    <= req;
      // Outputs are decoded from the next state so they leave a flop directly.
      S        <= (state_nx == ST_PULSE) && (cmd_nx == CMD_SET);
      R        <= (state_nx == ST_PULSE) && (cmd_nx == CMD_RST);
      preset   <= (state_nx == ST_PULSE) && (cmd_nx == CMD_PRE);
      clr      <= (state_nx == ST_INIT) ||
                  ((state_nx == ST_PULSE) && (cmd_nx == CMD_CLR));
      conflict <= conflict_nx;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sr_cmd_gen.sv
module tb_sr_cmd_gen;

  localparam int P = 2;
  localparam int G = 1;
  localparam int INIT = 4;
`ifdef SR_CMD_GEN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, set_req, rst_req, pre_req, clr_req;
  logic S, R, preset, clr, busy, conflict;

  int vectors = 0;
  int miscompares = 0;

  sr_cmd_gen dut (
    .clk(clk), .rst_n(rst_n),
    .set_req(set_req), .rst_req(rst_req), .pre_req(pre_req), .clr_req(clr_req),
    .S(S), .R(R), .preset(preset), .clr(clr), .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (time-stamp based) ----------------
  // Tracks edge number, when INIT ends, when the next command may start,
  // and when the current pulse started; outputs follow from those times.
  int m_t = 0, m_init_end = 0, m_free_at = 0, m_pstart = -1000, m_cmd = 0, m_k;
  logic [3:0] m_pend = '0, m_prev = '1, m_d1 = '1, m_d2 = '1;
  logic [3:0] m_raw, m_seen, m_ev;
  logic m_conf = 1'b0, m_inp;
  logic exp_S, exp_R, exp_pre, exp_clr, exp_busy, exp_conf;

  always @(posedge clk) begin
    m_t++;
    m_raw = {clr_req, pre_req, set_req, rst_req};
    if (!rst_n) begin
      m_init_end = m_t + INIT + 1;
      m_free_at  = m_init_end;
      m_pend = '0; m_prev = '1; m_d1 = '1; m_d2 = '1;
      m_pstart = -1000; m_conf = 1'b0;
    end else begin
`ifdef SR_CMD_GEN_SYNC_EN
      m_seen = m_d2; m_d2 = m_d1; m_d1 = m_raw;
`else
      m_seen = m_raw;
`endif
      m_ev = m_seen & ~m_prev;
      m_prev = m_seen;
      m_conf = 1'b0;
      if (m_t > m_init_end) begin
        if (m_ev[3]) m_pend = 4'b1000;
        else         m_pend = m_pend | m_ev;
        if (m_t >= m_free_at) begin
          m_k = -1;
          if (m_pend[3]) m_k = 3;
          else if (m_pend[2]) m_k = 2;
          else if (m_pend[1] && m_pend[0]) begin m_pend[1:0] = 2'b00; m_conf = 1'b1; end
          else if (m_pend[1]) m_k = 1;
          else if (m_pend[0]) m_k = 0;
          if (m_k >= 0) begin
            m_cmd = m_k; m_pstart = m_t; m_free_at = m_t + P + G; m_pend[m_k] = 1'b0;
          end
        end
      end
    end
    m_inp    = (m_t >= m_pstart) && (m_t < m_pstart + P);
    exp_S    = m_inp && (m_cmd == 1);
    exp_R    = m_inp && (m_cmd == 0);
    exp_pre  = m_inp && (m_cmd == 2);
    exp_clr  = (m_t < m_init_end) || (m_inp && (m_cmd == 3));
    exp_busy = (m_t < m_free_at);
    exp_conf = m_conf;
  end

  wire [5:0] exp_vec = {exp_S, exp_R, exp_pre, exp_clr, exp_busy, exp_conf};
  wire [5:0] dut_vec = {S, R, preset, clr, busy, conflict};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int clr_n = 0;
    int s_n = 0;
    rst_n = 1'b0; set_req = 1'b1; rst_req = 1'b0; pre_req = 1'b0; clr_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL reset_model got=%b exp=%b (S R pre clr busy conf)", dut_vec, exp_vec); end
    end
    vectors++;
    if (dut_vec !== 6'b000110) begin miscompares++;
      $display("FAIL reset_values got=%b exp=000110", dut_vec); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL init_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (clr) clr_n++;
      if (S) s_n++;
    end
    vectors++;
    if (clr_n !== INIT) begin miscompares++;
      $display("FAIL init_clr_len got=%0d exp=%0d", clr_n, INIT); end
    vectors++;
    if (s_n !== 0) begin miscompares++;
      $display("FAIL held_set_through_reset S_cycles got=%0d exp=0", s_n); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++;
      $display("FAIL init_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_single_set();
    int other_n = 0;
    set_req = 1'b0;
    repeat (3) @(negedge clk);
    set_req = 1'b1;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL set_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (R || preset || clr) other_n++;
      if (i == LAT - 1) begin
        vectors++;
        if (S !== 1'b0) begin miscompares++; $display("FAIL set_early got=%b exp=0", S); end
      end
      if (i == LAT || i == LAT + 1) begin
        vectors++;
        if (S !== 1'b1) begin miscompares++; $display("FAIL set_latency cyc=%0d got=%b exp=1", i, S); end
      end
      if (i == LAT + 2) begin
        vectors++;
        if ({S, busy} !== 2'b01) begin miscompares++;
          $display("FAIL set_guard got=%b exp=01 (S busy)", {S, busy}); end
      end
      if (i == LAT + 3) begin
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL set_idle busy got=%b exp=0", busy); end
      end
    end
    vectors++;
    if (other_n !== 0) begin miscompares++;
      $display("FAIL set_others cycles got=%0d exp=0", other_n); end
    set_req = 1'b0;
  endtask

  task automatic test_conflict();
    int conf_n = 0, sr_n = 0, busy_n = 0;
    set_req = 1'b0; rst_req = 1'b0;
    repeat (2) @(negedge clk);
    set_req = 1'b1; rst_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL conflict_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (conflict) conf_n++;
      if (S || R) sr_n++;
      if (busy) busy_n++;
    end
    vectors++;
    if (conf_n !== 1) begin miscompares++; $display("FAIL conflict_len got=%0d exp=1", conf_n); end
    vectors++;
    if (sr_n !== 0) begin miscompares++; $display("FAIL conflict_sr got=%0d exp=0", sr_n); end
    vectors++;
    if (busy_n !== 0) begin miscompares++; $display("FAIL conflict_busy got=%0d exp=0", busy_n); end
    set_req = 1'b0; rst_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int order[$];
    int starts[$];
    int exp_order[3] = '{1, 2, 0};
    logic ps = 1'b0, pr = 1'b0, pp = 1'b0;
    set_req = 1'b0; rst_req = 1'b0; pre_req = 1'b0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) set_req = 1'b1;
      if (i == 1) rst_req = 1'b1;
      if (i == 3) pre_req = 1'b1;
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL b2b_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (S && !ps)      begin order.push_back(1); starts.push_back(i); end
      if (preset && !pp) begin order.push_back(2); starts.push_back(i); end
      if (R && !pr)      begin order.push_back(0); starts.push_back(i); end
      ps = S; pr = R; pp = preset;
    end
    vectors++;
    if (order.size() !== 3) begin miscompares++;
      $display("FAIL b2b_count got=%0d exp=3", order.size()); end
    else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (order[j] !== exp_order[j]) begin miscompares++;
          $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", j, order[j], exp_order[j]); end
      end
      for (int j = 1; j < 3; j++) begin
        vectors++;
        if (starts[j] - starts[j-1] !== P + G) begin miscompares++;
          $display("FAIL b2b_period idx=%0d got=%0d exp=%0d", j, starts[j] - starts[j-1], P + G); end
      end
    end
    set_req = 1'b0; rst_req = 1'b0; pre_req = 1'b0;
  endtask

  task automatic test_clr_cancel();
    int s_n = 0, r_n = 0, c_n = 0;
    set_req = 1'b0; rst_req = 1'b0; pre_req = 1'b0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      if (i == 0) rst_req = 1'b1;
      if (i == 1) set_req = 1'b1;
      if (i == 2) clr_req = 1'b1;
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL clr_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (S) s_n++;
      if (R) r_n++;
      if (clr) c_n++;
    end
    vectors++;
    if (s_n !== 0) begin miscompares++; $display("FAIL clr_cancel S_cycles got=%0d exp=0", s_n); end
    vectors++;
    if (r_n !== P) begin miscompares++; $display("FAIL clr_cancel R_cycles got=%0d exp=%0d", r_n, P); end
    vectors++;
    if (c_n !== P) begin miscompares++; $display("FAIL clr_cancel clr_cycles got=%0d exp=%0d", c_n, P); end
    set_req = 1'b0; rst_req = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    bit seen = 1'b0;
    int s_n = 0, c_n = 0;
    set_req = 1'b0; rst_req = 1'b0; pre_req = 1'b0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    pre_req = 1'b1; set_req = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL rstmid_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (preset) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL rstmid_wait preset got=0 exp=1"); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({preset, clr, busy} !== 3'b011) begin miscompares++;
      $display("FAIL rstmid_edge got=%b exp=011 (preset clr busy)", {preset, clr, busy}); end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL rstmid_after cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      if (S) s_n++;
      if (clr) c_n++;
    end
    vectors++;
    if (s_n !== 0) begin miscompares++; $display("FAIL rstmid_pending S_cycles got=%0d exp=0", s_n); end
    vectors++;
    if (c_n !== INIT) begin miscompares++; $display("FAIL rstmid_init clr_cycles got=%0d exp=%0d", c_n, INIT); end
    pre_req = 1'b0; set_req = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3, 0) == 0) set_req = ~set_req;
      if ($urandom_range(3, 0) == 0) rst_req = ~rst_req;
      if ($urandom_range(5, 0) == 0) pre_req = ~pre_req;
      if ($urandom_range(9, 0) == 0) clr_req = ~clr_req;
      rst_n = ($urandom_range(79, 0) != 0);
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec) begin miscompares++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec); end
      vectors++;
      if ($countones({S, R, preset, clr}) > 1) begin miscompares++;
        $display("FAIL random_exclusive cyc=%0d got=%b exp=at most one high", i, {S, R, preset, clr}); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; set_req = 1'b1; rst_req = 1'b0; pre_req = 1'b0; clr_req = 1'b0;
    test_reset();
    test_single_set();
    test_conflict();
    test_back_to_back();
    test_clr_cancel();
    test_reset_mid_pulse();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
